// File: rtl/seq_slice_mult.sv
// rtl/seq_slice_mult.sv - sequential signed multiplier summing slice partial products on one shared core
module seq_slice_mult #(
  parameter int SLICE_W = 8,
  parameter int NSLICE  = 2,
  localparam int D_W = NSLICE * (SLICE_W - 1) + 1,
  localparam int P_W = 2 * D_W
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [D_W-1:0] i_a,
  input  logic [D_W-1:0] i_b,
  input  logic           i_skip_low,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [P_W-1:0] o_z,
  output logic           o_busy
);
  // Low slices are unsigned (S-1)-bit digits; the top slice carries the sign.
  localparam int S  = SLICE_W;
  localparam int DG = SLICE_W - 1;
  localparam int EW = P_W - 2 * SLICE_W;

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;
  state_t state_q, state_d;

  logic [D_W-1:0] a_q, b_q;
  logic           skip_q;
  logic [1:0]     i_q, j_q;
  logic [P_W-1:0] acc_q, z_q;
  logic [S-1:0]   sa, sb;
  logic [2*S-1:0] pp;
  logic [P_W-1:0] term;
  logic           last_pp;
  logic           accept;

  function automatic logic [S-1:0] slice_of(input logic [D_W-1:0] x, input logic [1:0] k);
    logic [D_W-1:0] sh;
    logic [S-1:0]   s;
    sh = x >> (int'(k) * DG);
    s  = sh[S-1:0];
    if (int'(k) != NSLICE - 1) s[S-1] = 1'b0;
    return s;
  endfunction

  assign last_pp = (int'(i_q) == NSLICE - 1) && (int'(j_q) == NSLICE - 1);
  assign accept  = i_valid && (state_q == IDLE);
  assign o_z     = z_q;

  // Current partial product: shared signed core, then sign-extend and weight by slice position.
  always_comb begin
    sa   = slice_of(a_q, i_q);
    sb   = slice_of(b_q, j_q);
    pp   = {{S{sa[S-1]}}, sa} * {{S{sb[S-1]}}, sb};
    term = {{EW{pp[2*S-1]}}, pp} << ((int'(i_q) + int'(j_q)) * DG);
    if (skip_q && (i_q == 2'd0) && (j_q == 2'd0)) term = '0;
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and handshake outputs; outputs depend on state only.
  always_comb begin
    state_d = state_q;
    o_ready = 1'b0;
    o_valid = 1'b0;
    o_busy  = 1'b0;
    case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_d = MUL;
      end
      MUL: begin
        o_busy = 1'b1;
        if (last_pp) state_d = DONE;
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, slice counters and accumulator; result register loads only on entry to DONE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      skip_q <= 1'b0;
      acc_q  <= '0;
      z_q    <= '0;
      i_q    <= '0;
      j_q    <= '0;
    end else if (accept) begin
      a_q    <= i_a;
      b_q    <= i_b;
      skip_q <= i_skip_low;
      acc_q  <= '0;
      i_q    <= '0;
      j_q    <= '0;
    end else if (state_q == MUL) begin
      acc_q <= acc_q + term;
      if (last_pp) z_q <= acc_q + term;
      if (int'(j_q) == NSLICE - 1) begin
        j_q <= '0;
        i_q <= i_q + 2'd1;
      end else begin
        j_q <= j_q + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_seq_slice_mult.sv
// tb/tb_seq_slice_mult.sv - randomized and directed self-checking bench for seq_slice_mult
module tb_seq_slice_mult;
  localparam int MDW = 15;
  localparam int MPW = 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Main instance, default parameters, directed tests.
  logic           m_rst_n, m_valid, m_skip, m_irdy;
  logic           m_oready, m_ovalid, m_busy;
  logic [MDW-1:0] m_a, m_b;
  logic [MPW-1:0] m_z;

  seq_slice_mult u_dut (
    .i_clk      (clk),
    .i_rst_n    (m_rst_n),
    .i_valid    (m_valid),
    .o_ready    (m_oready),
    .i_a        (m_a),
    .i_b        (m_b),
    .i_skip_low (m_skip),
    .o_valid    (m_ovalid),
    .i_ready    (m_irdy),
    .o_z        (m_z),
    .o_busy     (m_busy)
  );

  task automatic run_main(input longint av, input longint bv, input logic sk,
                          input string tag, input longint expz);
    int lat;
    @(negedge clk);
    check_val({tag, "_rdy"}, longint'(m_oready), 1);
    m_valid = 1'b1;
    m_a     = MDW'(av);
    m_b     = MDW'(bv);
    m_skip  = sk;
    m_irdy  = 1'b1;
    @(posedge clk);
    #1;
    m_valid = 1'b0;
    check_val({tag, "_busy"}, longint'(m_busy), 1);
    lat = 0;
    while (!m_ovalid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_val({tag, "_z"}, longint'($signed(m_z)), expz);
    check_val({tag, "_lat"}, longint'(lat), 4);
    @(posedge clk);
    #1;
  endtask

  // Parameter sweep instances, each with its own random stimulus.
  for (genvar g = 0; g < 6; g++) begin : g_sw
    localparam int SW = (g < 3) ? 4 : 8;
    localparam int NS = 2 + (g % 3);
    localparam int DW = NS * (SW - 1) + 1;
    localparam int PW = 2 * DW;

    logic          rst_n, iv, sk, ir, ordy, ov, bsy;
    logic [DW-1:0] a, b;
    logic [PW-1:0] z;
    logic          done = 1'b0;

    seq_slice_mult #(.SLICE_W(SW), .NSLICE(NS)) u_dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_valid    (iv),
      .o_ready    (ordy),
      .i_a        (a),
      .i_b        (b),
      .i_skip_low (sk),
      .o_valid    (ov),
      .i_ready    (ir),
      .o_z        (z),
      .o_busy     (bsy)
    );

    initial begin
      longint av, bv, ex, minv, maxv, lowmask;
      longint corner[4];
      int     lat;
      rst_n = 1'b0; iv = 1'b0; sk = 1'b0; ir = 1'b1; a = '0; b = '0;
      minv    = -(64'sd1 <<< (DW - 1));
      maxv    = (64'sd1 <<< (DW - 1)) - 1;
      lowmask = (64'sd1 <<< (SW - 1)) - 1;
      corner[0] = 0; corner[1] = -1; corner[2] = minv; corner[3] = maxv;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 1016; n++) begin
        @(negedge clk);
        if (n < 16) begin
          a  = DW'(corner[n % 4]);
          b  = DW'(corner[(n / 4) % 4]);
          sk = 1'b0;
        end else begin
          a  = DW'($urandom);
          b  = DW'($urandom);
          sk = ($urandom_range(0, 3) == 0);
        end
        av = longint'($signed(a));
        bv = longint'($signed(b));
        ex = av * bv - (sk ? (av & lowmask) * (bv & lowmask) : 64'sd0);
        check_val($sformatf("sw%0d_rdy", g), longint'(ordy), 1);
        iv = 1'b1;
        @(posedge clk);
        #1;
        iv = 1'b0;
        lat = 0;
        while (!ov && lat < 100) begin
          @(posedge clk);
          #1;
          lat++;
        end
        check_val($sformatf("sw%0d_z_n%0d", g, n), longint'($signed(z)), ex);
        check_val($sformatf("sw%0d_lat", g), longint'(lat), longint'(NS * NS));
        @(posedge clk);
        #1;
      end
      done = 1'b1;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    longint zhold, av, bv;
    longint acc_t[6];
    int     n;
    m_rst_n = 1'b0; m_valid = 1'b0; m_skip = 1'b0; m_irdy = 1'b1; m_a = '0; m_b = '0;
    repeat (3) @(negedge clk);
    m_rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_ready", longint'(m_oready), 1);
    check_val("rst_valid", longint'(m_ovalid), 0);
    check_val("rst_busy",  longint'(m_busy), 0);
    check_val("rst_z",     longint'(m_z), 0);

    run_main(16383, -16384, 1'b0, "max_min", -268419072);
    run_main(-16384, -16384, 1'b0, "min_min", 268435456);
    run_main(133, 3, 1'b1, "skip133", 384);
    run_main(127, 127, 1'b1, "skip127", 0);
    run_main(133, 3, 1'b0, "noskip133", 399);

    // Reset in the middle of a multiplication.
    @(negedge clk);
    m_valid = 1'b1; m_a = 15'd1000; m_b = 15'd1000; m_skip = 1'b0;
    @(posedge clk);
    #1 m_valid = 1'b0;
    @(posedge clk);
    #2 m_rst_n = 1'b0;
    #1;
    check_val("midrst_valid", longint'(m_ovalid), 0);
    check_val("midrst_busy",  longint'(m_busy), 0);
    check_val("midrst_z",     longint'(m_z), 0);
    check_val("midrst_ready", longint'(m_oready), 1);
    @(negedge clk);
    m_rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_val("midrst_noresult", longint'(m_ovalid), 0);
    run_main(-5, 7, 1'b0, "after_rst", -35);

    // Backpressure: result held, new operands ignored.
    @(negedge clk);
    m_valid = 1'b1; m_a = 15'(1234); m_b = 15'(-77); m_skip = 1'b0; m_irdy = 1'b0;
    @(posedge clk);
    #1 m_valid = 1'b0;
    n = 0;
    while (!m_ovalid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    zhold = -95018;
    check_val("bp_z", longint'($signed(m_z)), zhold);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      m_valid = 1'b1;
      m_a = 15'($urandom);
      m_b = 15'($urandom);
      @(posedge clk);
      #1;
      check_val($sformatf("bp_hold_z%0d", c), longint'($signed(m_z)), zhold);
      check_val($sformatf("bp_hold_rdy%0d", c), longint'(m_oready), 0);
      check_val($sformatf("bp_hold_vld%0d", c), longint'(m_ovalid), 1);
    end
    @(negedge clk);
    m_valid = 1'b0;
    m_irdy  = 1'b1;
    @(posedge clk);
    #1;
    check_val("bp_consumed_vld", longint'(m_ovalid), 0);
    check_val("bp_consumed_rdy", longint'(m_oready), 1);
    check_val("bp_z_kept", longint'($signed(m_z)), zhold);
    run_main(55, -3, 1'b0, "after_bp", -165);

    // Back-to-back with i_valid and i_ready held high.
    m_irdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      m_a = 15'($urandom);
      m_b = 15'($urandom);
      m_skip = 1'b0;
      m_valid = 1'b1;
      av = longint'($signed(m_a));
      bv = longint'($signed(m_b));
      n = 0;
      while (!m_oready && n < 50) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk);
      acc_t[k] = longint'($time);
      if (k > 0)
        check_val($sformatf("b2b_gap%0d", k), (acc_t[k] - acc_t[k-1]) / 10, 6);
      n = 0;
      @(negedge clk);
      while (!m_ovalid && n < 50) begin
        @(negedge clk);
        n++;
      end
      check_val($sformatf("b2b_z%0d", k), longint'($signed(m_z)), av * bv);
    end
    m_valid = 1'b0;

    wait (g_sw[0].done && g_sw[1].done && g_sw[2].done &&
          g_sw[3].done && g_sw[4].done && g_sw[5].done);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
